sdram_cpu_arb: RTL

- Slot scheduler in front of the CPU channel of the dual-bank SNES SDRAM controller; one grant per clkref slot.
- Arbitrates three requesters:
  - SNES CPU: absolute priority; never stalled.
  - ROM loader (ld_): background port.
  - Save/backup engine (bk_): background port.
- Background ports take only slots the CPU leaves idle, shared round-robin.
- CPU results use controller output register 0; background results use register 1. The CPU's read register is never disturbed.

---
 rtl/sdram_cpu_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_cpu_arb.sv
// Slot arbiter for the SDRAM CPU channel: CPU has absolute priority, loader and backup ports share idle slots round-robin.
// Optional slot statistics (stat_cpu/stat_bg/stat_idle, stat_clr) are built when SDRAM_ARB_STATS_EN is defined.
module sdram_cpu_arb #(
   parameter int STARVE_SLOTS = 64
`ifdef SDRAM_ARB_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkref,
   input  logic        sdram_busy,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [22:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_ds,
   input  logic        ld_req,
   input  logic        ld_we,
   input  logic [22:0] ld_addr,
   input  logic [15:0] ld_din,
   input  logic [1:0]  ld_ds,
   output logic        ld_busy,
   output logic        ld_ack,
   output logic [15:0] ld_dout,
   input  logic        bk_req,
   input  logic        bk_we,
   input  logic [22:0] bk_addr,
   input  logic [15:0] bk_din,
   input  logic [1:0]  bk_ds,
   output logic        bk_busy,
   output logic        bk_ack,
   output logic [15:0] bk_dout,
   output logic        ld_starve,
   output logic        bk_starve,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_ds,
   output logic        mem_port,
   input  logic [15:0] mem_q1
`ifdef SDRAM_ARB_STATS_EN
   , input  logic             stat_clr
   , output logic [CNT_W-1:0] stat_cpu
   , output logic [CNT_W-1:0] stat_bg
   , output logic [CNT_W-1:0] stat_idle
`endif
);

   localparam int SW = $clog2(STARVE_SLOTS + 1);

   typedef enum logic [1:0] {SLOT_IDLE = 2'd0, SLOT_CPU = 2'd1, SLOT_LD = 2'd2, SLOT_BK = 2'd3} slot_t;

   slot_t slot_q, slot_d;
   logic  clkref_r, slot_edge, rr_bk, bsel;

   // index 0 = loader, index 1 = backup engine
   logic [1:0]    req, we_in, busy, we_q, ack, elig, done, grant;
   logic [22:0]   addr_in [2];
   logic [22:0]   addr_q  [2];
   logic [15:0]   din_in  [2];
   logic [15:0]   din_q   [2];
   logic [15:0]   dout_q  [2];
   logic [1:0]    ds_in   [2];
   logic [1:0]    ds_q    [2];
   logic [SW-1:0] wait_cnt [2];

   assign req        = {bk_req, ld_req};
   assign we_in      = {bk_we, ld_we};
   assign addr_in[0] = ld_addr;
   assign addr_in[1] = bk_addr;
   assign din_in[0]  = ld_din;
   assign din_in[1]  = bk_din;
   assign ds_in[0]   = ld_ds;
   assign ds_in[1]   = bk_ds;

   assign slot_edge = clkref & ~clkref_r;

   // A port whose slot is just completing is still busy but must not be re-granted this edge.
   assign elig[0] = busy[0] & (slot_q != SLOT_LD);
   assign elig[1] = busy[1] & (slot_q != SLOT_BK);
   assign done[0] = slot_edge & (slot_q == SLOT_LD);
   assign done[1] = slot_edge & (slot_q == SLOT_BK);
   assign grant[0] = slot_edge & (slot_d == SLOT_LD);
   assign grant[1] = slot_edge & (slot_d == SLOT_BK);

   always_comb begin
      slot_d = SLOT_IDLE;
      if (sdram_busy)
         slot_d = SLOT_IDLE;
      else if (cpu_rd || cpu_wr)
         slot_d = SLOT_CPU;
      else if (elig[0] && elig[1])
         slot_d = rr_bk ? SLOT_BK : SLOT_LD;
      else if (elig[0])
         slot_d = SLOT_LD;
      else if (elig[1])
         slot_d = SLOT_BK;
      bsel = (slot_d == SLOT_BK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clkref_r <= 1'b0;
         slot_q   <= SLOT_IDLE;
         rr_bk    <= 1'b0;
      end else begin
         clkref_r <= clkref;
         if (slot_edge) begin
            slot_q <= slot_d;
            if (slot_d == SLOT_LD) rr_bk <= 1'b1;
            if (slot_d == SLOT_BK) rr_bk <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_ds   <= '0;
         mem_port <= 1'b0;
      end else if (slot_edge) begin
         case (slot_d)
            SLOT_CPU: begin
               mem_rd   <= cpu_rd & ~cpu_wr;
               mem_wr   <= cpu_wr;
               mem_addr <= cpu_addr;
               mem_din  <= cpu_din;
               mem_ds   <= cpu_ds;
               mem_port <= 1'b0;
            end
            SLOT_LD, SLOT_BK: begin
               mem_rd   <= ~we_q[bsel];
               mem_wr   <= we_q[bsel];
               mem_addr <= addr_q[bsel];
               mem_din  <= din_q[bsel];
               mem_ds   <= ds_q[bsel];
               mem_port <= 1'b1;
            end
            default: begin
               mem_rd   <= 1'b0;
               mem_wr   <= 1'b0;
               mem_port <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            busy[i]     <= 1'b0;
            ack[i]      <= 1'b0;
            we_q[i]     <= 1'b0;
            addr_q[i]   <= '0;
            din_q[i]    <= '0;
            ds_q[i]     <= '0;
            dout_q[i]   <= '0;
            wait_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            ack[i] <= 1'b0;
            if (req[i] && !busy[i]) begin
               busy[i]   <= 1'b1;
               we_q[i]   <= we_in[i];
               addr_q[i] <= addr_in[i];
               din_q[i]  <= din_in[i];
               ds_q[i]   <= ds_in[i];
            end
            if (done[i]) begin
               ack[i]  <= 1'b1;
               busy[i] <= 1'b0;
               if (!we_q[i]) dout_q[i] <= mem_q1;
            end
            if (grant[i])
               wait_cnt[i] <= '0;
            else if (slot_edge && elig[i] && wait_cnt[i] != SW'(STARVE_SLOTS))
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

   assign ld_busy   = busy[0];
   assign bk_busy   = busy[1];
   assign ld_ack    = ack[0];
   assign bk_ack    = ack[1];
   assign ld_dout   = dout_q[0];
   assign bk_dout   = dout_q[1];
   assign ld_starve = (wait_cnt[0] >= SW'(STARVE_SLOTS));
   assign bk_starve = (wait_cnt[1] >= SW'(STARVE_SLOTS));

`ifdef SDRAM_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cpu  <= '0;
         stat_bg   <= '0;
         stat_idle <= '0;
      end else if (stat_clr) begin
         stat_cpu  <= '0;
         stat_bg   <= '0;
         stat_idle <= '0;
      end else if (slot_edge) begin
         case (slot_d)
            SLOT_CPU:         if (stat_cpu != '1)  stat_cpu  <= stat_cpu + 1'b1;
            SLOT_LD, SLOT_BK: if (stat_bg != '1)   stat_bg   <= stat_bg + 1'b1;
            default:          if (stat_idle != '1) stat_idle <= stat_idle + 1'b1;
         endcase
      end
   end
`endif

endmodule
